// File: rtl/ad9958_init_sequencer.sv
// ad9958_init_sequencer
// Power-up / reconfiguration sequencer for the AD9958 DDS.
// On an accepted start it pulses MASTER_RESET, waits, serially writes the
// configuration registers (CSR, FR1, ACR per channel) over 3-wire SPI, and
// finishes with an IO_UPDATE pulse followed by a one-cycle done.
//
// Ports:
//   clk_i               system clock
//   rst_i               asynchronous active-high reset
//   start_i             begin sequence (sampled only in IDLE)
//   vco_gain_i          FR1[23]
//   clock_multiplier_i  FR1[22:18]
//   dac_fscale_ch0_i    ACR[9:8] for channel 0
//   dac_fscale_ch1_i    ACR[9:8] for channel 1
//   busy_o              high while the sequence runs
//   done_o              one-cycle pulse at sequence end
//   dds_reset_o         MASTER_RESET, active high
//   spi_cs_n_o          chip select, active low
//   spi_sclk_o          serial clock, idle low
//   spi_sdio_o          serial data, MSB first
//   io_update_o         IO_UPDATE
module ad9958_init_sequencer #(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 8,
  parameter int IOUP_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       vco_gain_i,
  input  logic [4:0] clock_multiplier_i,
  input  logic [1:0] dac_fscale_ch0_i,
  input  logic [1:0] dac_fscale_ch1_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       dds_reset_o,
  output logic       spi_cs_n_o,
  output logic       spi_sclk_o,
  output logic       spi_sdio_o,
  output logic       io_update_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DDS_RST, S_RST_WAIT, S_CS_SETUP, S_SHIFT_LO,
    S_SHIFT_HI, S_CS_HOLD, S_GAP, S_IOUP, S_DONE
  } state_t;

  localparam logic [2:0]  LAST_STEP = 3'd6;
  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [15:0] RST_M1    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] IOUP_M1   = 16'(IOUP_CYCLES - 1);

  // Left-justified frame (instruction byte + data) for a given step.
  function automatic logic [31:0] frame_word(input logic [2:0] step,
                                             input logic       vco,
                                             input logic [4:0] mult,
                                             input logic [1:0] fs0,
                                             input logic [1:0] fs1);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (step)
      3'd0:    w = {8'h00, 8'hC2, 16'h0000};
      3'd1:    w = {8'h01, vco, mult, 2'b11, 16'h0000};
      3'd2:    w = {8'h00, 8'h42, 16'h0000};
      3'd3:    w = {8'h06, 14'h0000, fs0, 8'h00};
      3'd4:    w = {8'h00, 8'h82, 16'h0000};
      3'd5:    w = {8'h06, 14'h0000, fs1, 8'h00};
      3'd6:    w = {8'h00, 8'hC2, 16'h0000};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Frame length minus one: FR1/ACR are 32 bits, CSR is 16 bits.
  function automatic logic [5:0] frame_bits_m1(input logic [2:0] step);
    logic [5:0] n;
    case (step)
      3'd1, 3'd3, 3'd5: n = 6'd31;
      default:          n = 6'd15;
    endcase
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] shift_q, shift_d;
  logic        vco_q, vco_d;
  logic [4:0]  mult_q, mult_d;
  logic [1:0]  fs0_q, fs0_d;
  logic [1:0]  fs1_q, fs1_d;
  logic        busy_q, done_q, dds_reset_q, cs_n_q, sclk_q, sdio_q, io_update_q;

  // Next-state logic: every timed state reloads cnt with its length minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    step_d  = step_q;
    shift_d = shift_q;
    vco_d   = vco_q;
    mult_d  = mult_q;
    fs0_d   = fs0_q;
    fs1_d   = fs1_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_DDS_RST;
          cnt_d   = RST_M1;
          step_d  = 3'd0;
          vco_d   = vco_gain_i;
          mult_d  = clock_multiplier_i;
          fs0_d   = dac_fscale_ch0_i;
          fs1_d   = dac_fscale_ch1_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DDS_RST: begin
        if (cnt_q == 16'd0) begin
          state_d = S_RST_WAIT;
          cnt_d   = RST_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_CS_SETUP;
          cnt_d   = DIV_M1;
          shift_d = frame_word(step_q, vco_q, mult_q, fs0_q, fs1_q);
          bit_d   = frame_bits_m1(step_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_SHIFT_LO;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == 16'd0) begin
          state_d = S_SHIFT_HI;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == 16'd0) begin
          // Shift on leaving the high half so sdio is stable across the rising edge.
          shift_d = {shift_q[30:0], 1'b0};
          cnt_d   = DIV_M1;
          if (bit_q == 6'd0) begin
            state_d = S_CS_HOLD;
          end else begin
            bit_d   = bit_q - 6'd1;
            state_d = S_SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = S_GAP;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd0) begin
          if (step_q == LAST_STEP) begin
            state_d = S_IOUP;
            cnt_d   = IOUP_M1;
          end else begin
            state_d = S_CS_SETUP;
            cnt_d   = DIV_M1;
            step_d  = step_q + 3'd1;
            shift_d = frame_word(step_q + 3'd1, vco_q, mult_q, fs0_q, fs1_q);
            bit_d   = frame_bits_m1(step_q + 3'd1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_IOUP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs (outputs decode the next state so they align with it).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_q       <= 6'd0;
      step_q      <= 3'd0;
      shift_q     <= 32'h0000_0000;
      vco_q       <= 1'b0;
      mult_q      <= 5'd0;
      fs0_q       <= 2'b00;
      fs1_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dds_reset_q <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdio_q      <= 1'b0;
      io_update_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      step_q      <= step_d;
      shift_q     <= shift_d;
      vco_q       <= vco_d;
      mult_q      <= mult_d;
      fs0_q       <= fs0_d;
      fs1_q       <= fs1_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      dds_reset_q <= (state_d == S_DDS_RST);
      cs_n_q      <= !((state_d == S_CS_SETUP) || (state_d == S_SHIFT_LO) ||
                       (state_d == S_SHIFT_HI) || (state_d == S_CS_HOLD));
      sclk_q      <= (state_d == S_SHIFT_HI);
      sdio_q      <= shift_d[31];
      io_update_q <= (state_d == S_IOUP);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dds_reset_o = dds_reset_q;
  assign spi_cs_n_o  = cs_n_q;
  assign spi_sclk_o  = sclk_q;
  assign spi_sdio_o  = sdio_q;
  assign io_update_o = io_update_q;

endmodule

// File: tb/tb_ad9958_init_sequencer.sv
// Self-checking bench for ad9958_init_sequencer: instance 0 uses the default
// parameters, instance 1 uses CLK_DIV=1, RST_CYCLES=1, IOUP_CYCLES=1.
module tb_ad9958_init_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_s;
  logic       vco;
  logic [4:0] mult;
  logic [1:0] fs0, fs1;
  logic [1:0] busy_s, done_s, dds_reset_s, cs_n_s, sclk_s, sdio_s, io_update_s;

  int total;
  int bad;

  // frame capture per instance
  logic [31:0] frm [2][16];
  int          flen [2][16];
  int          fcnt [2];
  int          dcnt [2];
  logic [31:0] cur [2];
  int          nb [2], hr [2], lr [2], csh [2], rr [2], ir [2];
  logic [1:0]  fell, p_cs, p_sclk, p_sdio, p_rs, p_io;

  typedef struct {
    logic        vco;
    logic [4:0]  mult;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [31:0] fr1;
    logic [31:0] acr0;
    logic [31:0] acr1;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  ad9958_init_sequencer dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]),
    .vco_gain_i(vco), .clock_multiplier_i(mult),
    .dac_fscale_ch0_i(fs0), .dac_fscale_ch1_i(fs1),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .dds_reset_o(dds_reset_s[0]),
    .spi_cs_n_o(cs_n_s[0]), .spi_sclk_o(sclk_s[0]), .spi_sdio_o(sdio_s[0]),
    .io_update_o(io_update_s[0])
  );

  ad9958_init_sequencer #(.CLK_DIV(1), .RST_CYCLES(1), .IOUP_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]),
    .vco_gain_i(vco), .clock_multiplier_i(mult),
    .dac_fscale_ch0_i(fs0), .dac_fscale_ch1_i(fs1),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .dds_reset_o(dds_reset_s[1]),
    .spi_cs_n_o(cs_n_s[1]), .spi_sclk_o(sclk_s[1]), .spi_sdio_o(sdio_s[1]),
    .io_update_o(io_update_s[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hw(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int rw(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  // SPI decoder and waveform timing checks, sampled on the falling clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        p_cs[k] = 1'b1; p_sclk[k] = 1'b0; p_sdio[k] = 1'b0; p_rs[k] = 1'b0; p_io[k] = 1'b0;
        fell[k] = 1'b0; cur[k] = 32'h0;
        nb[k] = 0; hr[k] = 0; lr[k] = 0; csh[k] = 0; rr[k] = 0; ir[k] = 0;
      end else begin
        if (done_s[k]) dcnt[k]++;
        if (dds_reset_s[k]) rr[k] = p_rs[k] ? rr[k] + 1 : 1;
        else if (p_rs[k]) chk($sformatf("dds_reset_width%0d", k), rr[k], rw(k));
        if (io_update_s[k]) begin
          if (!p_io[k]) begin
            chk($sformatf("ioup_after_cs%0d", k), 32'(cs_n_s[k]), 32'd1);
            chk($sformatf("ioup_frames%0d", k), fcnt[k], 32'd7);
            ir[k] = 1;
          end else begin
            ir[k]++;
          end
        end else if (p_io[k]) begin
          chk($sformatf("ioup_width%0d", k), ir[k], hw(k));
        end
        if (!cs_n_s[k] && p_cs[k]) begin
          if (fcnt[k] > 0) chk($sformatf("cs_gap%0d", k), csh[k], hw(k));
          nb[k] = 0; cur[k] = 32'h0; fell[k] = 1'b0;
        end
        if (cs_n_s[k] && !p_cs[k]) begin
          if (fcnt[k] < 16) begin
            frm[k][fcnt[k]]  = cur[k];
            flen[k][fcnt[k]] = nb[k];
          end
          fcnt[k]++;
          csh[k] = 1;
        end else if (cs_n_s[k]) begin
          csh[k]++;
        end
        if (sclk_s[k] && !p_sclk[k]) begin
          chk($sformatf("sdio_stable%0d", k), 32'(sdio_s[k]), 32'(p_sdio[k]));
          if (fell[k]) chk($sformatf("sclk_low%0d", k), lr[k], hw(k));
          cur[k] = {cur[k][30:0], sdio_s[k]};
          nb[k]++;
          hr[k] = 1;
        end else if (sclk_s[k] && p_sclk[k]) begin
          hr[k]++;
        end else if (!sclk_s[k] && p_sclk[k]) begin
          chk($sformatf("sclk_high%0d", k), hr[k], hw(k));
          lr[k] = 1;
          fell[k] = 1'b1;
        end else begin
          lr[k]++;
        end
        p_cs[k] = cs_n_s[k]; p_sclk[k] = sclk_s[k]; p_sdio[k] = sdio_s[k];
        p_rs[k] = dds_reset_s[k]; p_io[k] = io_update_s[k];
      end
    end
  end

  // One start on instance k; optional mid-run start pulse and input change.
  task automatic run_seq(input int k, input int lat, input int mid_at, input bit chg);
    int n;
    int d0;
    fcnt[k] = 0;
    d0 = dcnt[k];
    @(negedge clk);
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    n = 1;
    chk($sformatf("busy_after_start%0d", k), 32'(busy_s[k]), 32'd1);
    while (!done_s[k] && n < 4000) begin
      @(posedge clk); #1;
      n++;
      start_s[k] = (n == mid_at);
      if (chg && n == 100) begin
        mult = 5'd20;
        fs1  = 2'b11;
      end
    end
    start_s[k] = 1'b0;
    chk($sformatf("latency%0d", k), n, lat);
    chk($sformatf("busy_in_done%0d", k), 32'(busy_s[k]), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("done_one_cycle%0d", k), 32'(done_s[k]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk($sformatf("done_count%0d", k), dcnt[k] - d0, 32'd1);
  endtask

  task automatic check_frames(input int k, input logic [31:0] fr1,
                              input logic [31:0] acr0, input logic [31:0] acr1);
    logic [31:0] ef [7];
    int          el [7];
    ef = '{32'h0000_00C2, fr1, 32'h0000_0042, acr0, 32'h0000_0082, acr1, 32'h0000_00C2};
    el = '{16, 32, 16, 32, 16, 32, 16};
    chk($sformatf("frame_count%0d", k), fcnt[k], 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("frame%0d_%0d", k, i), frm[k][i], ef[i]);
      chk($sformatf("frame_len%0d_%0d", k, i), flen[k][i], el[i]);
    end
  endtask

  initial begin
    int n;
    int d0;
    total = 0; bad = 0;
    rst = 1'b1; start_s = 2'b00;
    vco = 1'b1; mult = 5'd10; fs0 = 2'b01; fs1 = 2'b01;
    fcnt[0] = 0; fcnt[1] = 0; dcnt[0] = 0; dcnt[1] = 0;
    vecs[0] = '{1'b1, 5'd10, 2'b01, 2'b01, 32'h01AB_0000, 32'h0600_0100, 32'h0600_0100};
    vecs[1] = '{1'b0, 5'd0,  2'b00, 2'b00, 32'h0103_0000, 32'h0600_0000, 32'h0600_0000};
    vecs[2] = '{1'b1, 5'd31, 2'b11, 2'b10, 32'h01FF_0000, 32'h0600_0300, 32'h0600_0200};
    vecs[3] = '{1'b0, 5'd20, 2'b10, 2'b11, 32'h0153_0000, 32'h0600_0200, 32'h0600_0300};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(busy_s[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(done_s[k]), 32'd0);
      chk($sformatf("rst_ddsrst%0d", k), 32'(dds_reset_s[k]), 32'd0);
      chk($sformatf("rst_csn%0d", k), 32'(cs_n_s[k]), 32'd1);
      chk($sformatf("rst_sclk%0d", k), 32'(sclk_s[k]), 32'd0);
      chk($sformatf("rst_sdio%0d", k), 32'(sdio_s[k]), 32'd0);
      chk($sformatf("rst_ioup%0d", k), 32'(io_update_s[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // table-driven frame content and latency
    for (int i = 0; i < 4; i++) begin
      vco = vecs[i].vco; mult = vecs[i].mult; fs0 = vecs[i].f0; fs1 = vecs[i].f1;
      run_seq(0, 1385, 0, 1'b0);
      check_frames(0, vecs[i].fr1, vecs[i].acr0, vecs[i].acr1);
    end

    // start pulsed mid-sequence is ignored
    vco = 1'b1; mult = 5'd10; fs0 = 2'b01; fs1 = 2'b01;
    run_seq(0, 1385, 500, 1'b0);
    check_frames(0, 32'h01AB_0000, 32'h0600_0100, 32'h0600_0100);

    // inputs changed while busy have no effect; next start picks them up
    run_seq(0, 1385, 0, 1'b1);
    check_frames(0, 32'h01AB_0000, 32'h0600_0100, 32'h0600_0100);
    run_seq(0, 1385, 0, 1'b0);
    chk("fr1_mult_new", 32'(frm[0][1][22:18]), 32'd20);
    chk("acr1_fscale_new", 32'(frm[0][5][9:8]), 32'd3);
    chk("fr1_new", frm[0][1], 32'h01D3_0000);

    // reset during frame 3, bit 10
    mult = 5'd10; fs1 = 2'b01;
    fcnt[0] = 0;
    d0 = dcnt[0];
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    n = 0;
    while (!(fcnt[0] == 3 && nb[0] == 10) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_point_reached", 32'(n < 3000), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_csn", 32'(cs_n_s[0]), 32'd1);
    chk("abort_sclk", 32'(sclk_s[0]), 32'd0);
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    chk("abort_ioup", 32'(io_update_s[0]), 32'd0);
    @(posedge clk); #1;
    chk("abort_csn_next", 32'(cs_n_s[0]), 32'd1);
    chk("abort_busy_next", 32'(busy_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    chk("abort_no_done", dcnt[0] - d0, 32'd0);
    chk("abort_idle", 32'(busy_s[0]), 32'd0);
    run_seq(0, 1385, 0, 1'b0);
    check_frames(0, 32'h01AB_0000, 32'h0600_0100, 32'h0600_0100);

    // minimum-timing instance
    run_seq(1, 345, 0, 1'b0);
    check_frames(1, 32'h01AB_0000, 32'h0600_0100, 32'h0600_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
